edn_endpoint_rsp: RTL



---
 rtl/edn_pkg.sv | 13 +
 rtl/edn_word_unpacker.sv | 49 ++++
 rtl/edn_endpoint_rsp.sv | 68 ++++++
 3 files changed

// File: rtl/edn_pkg.sv
// edn_pkg: shared EDN endpoint bus width, request/response types and reset constant.
package edn_pkg;
  localparam int unsigned ENDPOINT_BUS_WIDTH = 32;
  typedef struct packed {
    logic edn_req;
  } edn_req_t;
  typedef struct packed {
    logic                          edn_ack;
    logic                          edn_fips;
    logic [ENDPOINT_BUS_WIDTH-1:0] edn_bus;
  } edn_rsp_t;
  localparam edn_rsp_t EDN_RSP_DEFAULT = '0;
endpackage

// File: rtl/edn_word_unpacker.sv
// edn_word_unpacker: holds one entropy block and steps through its bus-width words.
module edn_word_unpacker
  import edn_pkg::*;
#(
  parameter int unsigned InWidth  = 128,
  parameter int unsigned BusWidth = ENDPOINT_BUS_WIDTH,
  localparam int unsigned NumWords = InWidth / BusWidth,
  localparam int unsigned IdxW     = NumWords > 1 ? $clog2(NumWords) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [InWidth-1:0]  load_data_i,
  input  logic                load_fips_i,
  input  logic                advance_i,
  output logic [BusWidth-1:0] word_o,
  output logic                fips_o,
  output logic                valid_o,
  output logic                last_o
);
  logic [NumWords-1:0][BusWidth-1:0] buf_q, buf_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic buf_fips_q, buf_fips_d, buf_valid_q, buf_valid_d;
  assign word_o  = buf_q[idx_q];
  assign fips_o  = buf_fips_q;
  assign valid_o = buf_valid_q;
  assign last_o  = idx_q == IdxW'(NumWords - 1);
  // A load only happens when the buffer is empty or its last word is leaving, so load may override advance.
  always_comb begin
    buf_d       = load_i ? load_data_i : buf_q;
    buf_fips_d  = load_i ? load_fips_i : buf_fips_q;
    idx_d       = (clear_i || load_i) ? '0 : advance_i ? (last_o ? '0 : idx_q + 1'b1) : idx_q;
    buf_valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : (advance_i && last_o) ? 1'b0 : buf_valid_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q       <= '0;
      buf_fips_q  <= 1'b0;
      idx_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_fips_q  <= buf_fips_d;
      idx_q       <= idx_d;
      buf_valid_q <= buf_valid_d;
    end
  end
endmodule

// File: rtl/edn_endpoint_rsp.sv
// edn_endpoint_rsp: EDN-side responder of the endpoint req/ack protocol.
// Unpacks wide entropy blocks and serves one bus word per request; the bus holds between acks.
module edn_endpoint_rsp
  import edn_pkg::*;
#(
  parameter int unsigned InWidth  = 128,
  parameter int unsigned BusWidth = ENDPOINT_BUS_WIDTH,
  parameter int unsigned CntW     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               gen_valid_i,
  output logic               gen_ready_o,
  input  logic [InWidth-1:0] gen_bits_i,
  input  logic               gen_fips_i,
  input  edn_req_t           edn_i,
  output edn_rsp_t           edn_o,
  output logic               empty_o,
  output logic [CntW-1:0]    served_cnt_o
);
  if (InWidth % BusWidth != 0 || InWidth < BusWidth) begin : g_bad_width
    $error("InWidth must be a nonzero multiple of BusWidth");
  end
  edn_rsp_t rsp_q, rsp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BusWidth-1:0] word;
  logic word_fips, buf_valid, last, serve, load;
  // The ~ack guard forces at least two cycles between acks so a slow consumer sees each edge.
  assign serve        = enable_i & edn_i.edn_req & buf_valid & ~rsp_q.edn_ack;
  assign gen_ready_o  = enable_i & (~buf_valid | (serve & last));
  assign load         = gen_valid_i & gen_ready_o;
  assign empty_o      = ~buf_valid;
  assign edn_o        = rsp_q;
  assign served_cnt_o = cnt_q;
  edn_word_unpacker #(
    .InWidth (InWidth),
    .BusWidth(BusWidth)
  ) u_unpacker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (~enable_i),
    .load_i     (load),
    .load_data_i(gen_bits_i),
    .load_fips_i(gen_fips_i),
    .advance_i  (serve),
    .word_o     (word),
    .fips_o     (word_fips),
    .valid_o    (buf_valid),
    .last_o     (last)
  );
  always_comb begin
    rsp_d          = rsp_q;
    rsp_d.edn_ack  = serve;
    rsp_d.edn_fips = serve ? word_fips : rsp_q.edn_fips;
    rsp_d.edn_bus  = serve ? word : rsp_q.edn_bus;
    cnt_d          = !enable_i ? '0 : (rsp_q.edn_ack && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= EDN_RSP_DEFAULT;
      cnt_q <= '0;
    end else begin
      rsp_q <= rsp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
